memory_bank_ctrl: RTL and testbench

Parametrised successor of the single-port data memory bank. Wraps a 2^ADDR_SIZE x WORD_SIZE array behind a valid/ready request port and a one-cycle response pulse. Adds byte-lane write enables, configurable access latency (wait states) and an optional post-reset clear sequence. Sits between the core's load/store unit and data storage.

---
 rtl/memory_bank_ctrl_pkg.sv | 15 +
 rtl/memory_bank_ctrl_if.sv | 34 +++
 rtl/memory_bank_ctrl_lane_merge.sv | 20 ++
 rtl/memory_bank_ctrl.sv | 147 ++++++++++++++
 tb/tb_memory_bank_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/memory_bank_ctrl_pkg.sv
// Shared constants for the data memory bank controller: default geometry,
// lane size and the 2-bit FSM state encodings.
package memory_bank_ctrl_pkg;

    localparam int DATA_WORD_SIZE  = 32;
    localparam int DATA_ADDR_SIZE  = 10;
    localparam int MEM_LANE_SIZE   = 8;
    localparam int MEM_MAX_LATENCY = 8;

    localparam logic [1:0] MEM_ST_INIT = 2'd0;
    localparam logic [1:0] MEM_ST_IDLE = 2'd1;
    localparam logic [1:0] MEM_ST_WAIT = 2'd2;
    localparam logic [1:0] MEM_ST_RESP = 2'd3;

endpackage

// File: rtl/memory_bank_ctrl_if.sv
// Request/response port of the memory bank. A request transfers on a rising edge with
// req_valid && req_ready; rsp_valid is a one-cycle strobe that is never back-pressured.
interface memory_bank_ctrl_if
    import memory_bank_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = DATA_WORD_SIZE,
    parameter int ADDR_SIZE = DATA_ADDR_SIZE,
    parameter int LANE_SIZE = MEM_LANE_SIZE
) ();

    localparam int LANES = WORD_SIZE / LANE_SIZE;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [LANES-1:0]     req_be;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 rsp_valid;
    logic [WORD_SIZE-1:0] rsp_rdata;
    logic                 busy;
    logic [1:0]           dbg_state;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy, dbg_state
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy, dbg_state
    );

endinterface

// File: rtl/memory_bank_ctrl_lane_merge.sv
// Byte-lane write merge: each lane takes the new data where its enable is set,
// otherwise keeps the old word's lane.
module mem_lane_merge #(
    parameter int WORD_SIZE = 32,
    parameter int LANE_SIZE = 8
) (
    input  logic [WORD_SIZE-1:0]           old_i,
    input  logic [WORD_SIZE-1:0]           wdata_i,
    input  logic [WORD_SIZE/LANE_SIZE-1:0] be_i,
    output logic [WORD_SIZE-1:0]           merged_o
);

    localparam int LANES = WORD_SIZE / LANE_SIZE;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign merged_o[g*LANE_SIZE +: LANE_SIZE] =
            be_i[g] ? wdata_i[g*LANE_SIZE +: LANE_SIZE] : old_i[g*LANE_SIZE +: LANE_SIZE];
    end

endmodule

// File: rtl/memory_bank_ctrl.sv
// Single-port data memory bank with valid/ready requests, byte-lane writes,
// configurable access latency and an optional post-reset clear sweep.
module memory_bank_ctrl
    import memory_bank_ctrl_pkg::*;
#(
    parameter int WORD_SIZE      = DATA_WORD_SIZE,
    parameter int ADDR_SIZE      = DATA_ADDR_SIZE,
    parameter int LANE_SIZE      = MEM_LANE_SIZE,
    parameter int LATENCY        = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic              clk,
    input logic              rst,
    memory_bank_ctrl_if.slave bus
);

    localparam int         LANES       = WORD_SIZE / LANE_SIZE;
    localparam int         DEPTH       = 1 << ADDR_SIZE;
    localparam logic [2:0] WAIT_LOAD   = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;
    localparam logic [1:0] RESET_STATE = CLEAR_ON_RESET ? MEM_ST_INIT : MEM_ST_IDLE;

    logic [1:0]           state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0] clr_q, clr_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic                 we_q, we_d;
    logic [LANES-1:0]     be_q, be_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;

    logic [WORD_SIZE-1:0] bank_q [DEPTH];

    logic                 req_ready;
    logic                 accept;
    logic                 enter_resp;
    logic                 op_we;
    logic [ADDR_SIZE-1:0] op_addr;
    logic [LANES-1:0]     op_be;
    logic [WORD_SIZE-1:0] op_wdata;
    logic [WORD_SIZE-1:0] old_word;
    logic [WORD_SIZE-1:0] merged;

    assign req_ready = (state_q == MEM_ST_IDLE) || (state_q == MEM_ST_RESP);
    assign accept    = bus.req_valid && req_ready;

    // With LATENCY=1 the array op happens on the accept edge itself, so the
    // live request feeds the array; otherwise the captured copy does.
    assign op_we    = (state_q == MEM_ST_WAIT) ? we_q    : bus.req_we;
    assign op_addr  = (state_q == MEM_ST_WAIT) ? addr_q  : bus.req_addr;
    assign op_be    = (state_q == MEM_ST_WAIT) ? be_q    : bus.req_be;
    assign op_wdata = (state_q == MEM_ST_WAIT) ? wdata_q : bus.req_wdata;
    assign old_word = bank_q[op_addr];

    mem_lane_merge #(
        .WORD_SIZE (WORD_SIZE),
        .LANE_SIZE (LANE_SIZE)
    ) u_merge (
        .old_i    (old_word),
        .wdata_i  (op_wdata),
        .be_i     (op_be),
        .merged_o (merged)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_d      = clr_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        enter_resp = 1'b0;
        case (state_q)
            MEM_ST_INIT: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == '1) state_d = MEM_ST_IDLE;
            end
            MEM_ST_IDLE, MEM_ST_RESP: begin
                if (accept) begin
                    addr_d  = bus.req_addr;
                    we_d    = bus.req_we;
                    be_d    = bus.req_be;
                    wdata_d = bus.req_wdata;
                    if (LATENCY == 1) begin
                        state_d    = MEM_ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = MEM_ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else if (state_q == MEM_ST_RESP) begin
                    state_d = MEM_ST_IDLE;
                end
            end
            MEM_ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d    = MEM_ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = RESET_STATE;
        endcase
        // A zero-enable write merges to the old word, so it reads back unchanged.
        if (enter_resp) rdata_d = op_we ? merged : old_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            clr_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage has no reset; contents are only zeroed by the INIT sweep.
    always_ff @(posedge clk) begin
        if (state_q == MEM_ST_INIT) begin
            bank_q[clr_q] <= '0;
        end else if (enter_resp && op_we) begin
            bank_q[op_addr] <= merged;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == MEM_ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.busy      = (state_q != MEM_ST_IDLE);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_memory_bank_ctrl.sv
// Directed bench for memory_bank_ctrl: a LATENCY=3 clearing instance and a
// LATENCY=1 non-clearing instance, 16-bit words, 16-entry bank.
module tb_memory_bank_ctrl;
    import memory_bank_ctrl_pkg::*;

    typedef struct {
        logic        we;
        logic [1:0]  be;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    logic clk;
    logic a_rst;
    logic b_rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    memory_bank_ctrl_if #(.WORD_SIZE(16), .ADDR_SIZE(4), .LANE_SIZE(8)) a_if ();
    memory_bank_ctrl_if #(.WORD_SIZE(16), .ADDR_SIZE(4), .LANE_SIZE(8)) b_if ();

    memory_bank_ctrl #(
        .WORD_SIZE(16), .ADDR_SIZE(4), .LANE_SIZE(8), .LATENCY(3), .CLEAR_ON_RESET(1'b1)
    ) dut_a (
        .clk (clk),
        .rst (a_rst),
        .bus (a_if)
    );

    memory_bank_ctrl #(
        .WORD_SIZE(16), .ADDR_SIZE(4), .LANE_SIZE(8), .LATENCY(1), .CLEAR_ON_RESET(1'b0)
    ) dut_b (
        .clk (clk),
        .rst (b_rst),
        .bus (b_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at the negedge where reset was just released; counts INIT cycles.
    task automatic count_init(input string name);
        int  cnt;
        bit  busy_ok;
        bit  quiet;
        cnt     = 0;
        busy_ok = 1'b1;
        quiet   = 1'b1;
        while (!a_if.req_ready && cnt < 40) begin
            if (!a_if.busy) busy_ok = 1'b0;
            if (a_if.rsp_valid) quiet = 1'b0;
            cnt++;
            @(negedge clk);
        end
        check({name, " init_cycles"}, 32'(cnt), 32'd16);
        check({name, " init_busy"}, 32'(busy_ok), 32'd1);
        check({name, " init_no_rsp"}, 32'(quiet), 32'd1);
        check({name, " idle_busy"}, 32'(a_if.busy), 32'd0);
    endtask

    // Issue one request on instance A and check its latency, data and strobe width.
    task automatic req_a(input vec_t v, input string name);
        int n;
        n = 0;
        while (!a_if.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, " ready"}, 32'(a_if.req_ready), 32'd1);
        a_if.req_we    = v.we;
        a_if.req_be    = v.be;
        a_if.req_addr  = v.addr;
        a_if.req_wdata = v.wdata;
        a_if.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_if.req_valid = 1'b0;
        n = 1;
        while (!a_if.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd3);
        check({name, " rdata"}, 32'(a_if.rsp_rdata), 32'(v.exp_rdata));
        @(negedge clk);
        check({name, " rsp_drop"}, 32'(a_if.rsp_valid), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        a_rst = 1'b1;
        b_rst = 1'b1;
        a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_be = '0;
        a_if.req_addr  = '0;   a_if.req_wdata = '0;
        b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_be = '0;
        b_if.req_addr  = '0;   b_if.req_wdata = '0;

        for (int i = 0; i < 16; i++) vecs.push_back('{1'b0, 2'b00, 4'(i), 16'h0000, 16'h0000});
        vecs.push_back('{1'b1, 2'b11, 4'd5, 16'hBEEF, 16'hBEEF});
        vecs.push_back('{1'b0, 2'b00, 4'd5, 16'h0000, 16'hBEEF});
        vecs.push_back('{1'b1, 2'b01, 4'd5, 16'h1234, 16'hBE34});
        vecs.push_back('{1'b1, 2'b00, 4'd5, 16'hFFFF, 16'hBE34});
        vecs.push_back('{1'b0, 2'b11, 4'd5, 16'hFFFF, 16'hBE34});

        repeat (2) @(negedge clk);
        check("a_rst ready", 32'(a_if.req_ready), 32'd0);
        check("a_rst busy", 32'(a_if.busy), 32'd1);
        check("a_rst rsp_valid", 32'(a_if.rsp_valid), 32'd0);
        check("a_rst rdata", 32'(a_if.rsp_rdata), 32'd0);
        check("b_rst ready", 32'(b_if.req_ready), 32'd1);
        check("b_rst busy", 32'(b_if.busy), 32'd0);
        check("b_rst rsp_valid", 32'(b_if.rsp_valid), 32'd0);
        check("b_rst rdata", 32'(b_if.rsp_rdata), 32'd0);

        a_rst = 1'b0;
        b_rst = 1'b0;
        count_init("clear");

        foreach (vecs[i]) req_a(vecs[i], $sformatf("vec%0d", i));

        // Request held through WAIT is only taken in the RESP cycle.
        a_if.req_we = 1'b0; a_if.req_addr = 4'd5; a_if.req_be = 2'b00;
        a_if.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_if.req_we = 1'b1; a_if.req_be = 2'b11; a_if.req_addr = 4'd6; a_if.req_wdata = 16'h7777;
        check("hold w1 ready", 32'(a_if.req_ready), 32'd0);
        check("hold w1 rsp", 32'(a_if.rsp_valid), 32'd0);
        @(negedge clk);
        check("hold w2 ready", 32'(a_if.req_ready), 32'd0);
        check("hold w2 rsp", 32'(a_if.rsp_valid), 32'd0);
        @(negedge clk);
        check("hold resp rsp", 32'(a_if.rsp_valid), 32'd1);
        check("hold resp rdata", 32'(a_if.rsp_rdata), 32'h0000BE34);
        check("hold resp ready", 32'(a_if.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        a_if.req_valid = 1'b0;
        check("hold2 c1 rsp", 32'(a_if.rsp_valid), 32'd0);
        check("hold2 c1 state", 32'(a_if.dbg_state), 32'(MEM_ST_WAIT));
        @(negedge clk);
        check("hold2 c2 rsp", 32'(a_if.rsp_valid), 32'd0);
        @(negedge clk);
        check("hold2 c3 rsp", 32'(a_if.rsp_valid), 32'd1);
        check("hold2 c3 rdata", 32'(a_if.rsp_rdata), 32'h00007777);
        @(negedge clk);
        check("hold2 c4 rsp", 32'(a_if.rsp_valid), 32'd0);
        req_a('{1'b0, 2'b00, 4'd6, 16'h0000, 16'h7777}, "rd6");

        // Back-to-back single-cycle requests on instance B.
        b_if.req_we = 1'b1; b_if.req_be = 2'b11; b_if.req_addr = 4'd2; b_if.req_wdata = 16'h00AA;
        b_if.req_valid = 1'b1;
        check("b idle rsp", 32'(b_if.rsp_valid), 32'd0);
        @(negedge clk);
        check("b r1 rsp", 32'(b_if.rsp_valid), 32'd1);
        check("b r1 rdata", 32'(b_if.rsp_rdata), 32'h000000AA);
        check("b r1 ready", 32'(b_if.req_ready), 32'd1);
        b_if.req_we = 1'b0;
        @(negedge clk);
        check("b r2 rsp", 32'(b_if.rsp_valid), 32'd1);
        check("b r2 rdata", 32'(b_if.rsp_rdata), 32'h000000AA);
        b_if.req_we = 1'b1; b_if.req_addr = 4'd3; b_if.req_wdata = 16'h5555;
        @(negedge clk);
        check("b r3 rsp", 32'(b_if.rsp_valid), 32'd1);
        check("b r3 rdata", 32'(b_if.rsp_rdata), 32'h00005555);
        b_if.req_valid = 1'b0;
        @(negedge clk);
        check("b r4 rsp", 32'(b_if.rsp_valid), 32'd0);
        check("b r4 rdata_hold", 32'(b_if.rsp_rdata), 32'h00005555);
        check("b r4 busy", 32'(b_if.busy), 32'd0);

        // Reset during the first WAIT cycle of a write aborts it.
        a_if.req_we = 1'b1; a_if.req_be = 2'b11; a_if.req_addr = 4'd7; a_if.req_wdata = 16'hCAFE;
        a_if.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_if.req_valid = 1'b0;
        check("abort pre state", 32'(a_if.dbg_state), 32'(MEM_ST_WAIT));
        a_rst = 1'b1;
        #1;
        check("abort rsp", 32'(a_if.rsp_valid), 32'd0);
        check("abort ready", 32'(a_if.req_ready), 32'd0);
        check("abort state", 32'(a_if.dbg_state), 32'(MEM_ST_INIT));
        @(negedge clk);
        check("abort hold rsp", 32'(a_if.rsp_valid), 32'd0);
        @(negedge clk);
        check("abort hold2 rsp", 32'(a_if.rsp_valid), 32'd0);
        a_rst = 1'b0;
        count_init("reclear");
        req_a('{1'b0, 2'b00, 4'd7, 16'h0000, 16'h0000}, "rd7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
